// File: rtl/mdr_mem_sequencer_pkg.sv
// Shared definitions for the MDR memory sequencer: state encoding, op encoding,
// MDR direction values and tie-pointer values.
package mdr_mem_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ADDR    = 3'd1,
      ST_RWAIT   = 3'd2,
      ST_RLATCH  = 3'd3,
      ST_RDRIVE  = 3'd4,
      ST_WLOAD   = 3'd5,
      ST_WSTROBE = 3'd6,
      ST_WDONE   = 3'd7
   } seq_state_e;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } seq_op_e;

   localparam logic RM_READ   = 1'b0;
   localparam logic RM_WRITE  = 1'b1;

   localparam logic PTR_FETCH = 1'b0;
   localparam logic PTR_EXEC  = 1'b1;

endpackage

// File: rtl/mdr_mem_sequencer_if.sv
// Request/handshake and MDR/RAM control bundle between the control unit and
// the sequencer.
interface mdr_mem_sequencer_if;

   logic iReqFetch;
   logic iReqExec;
   logic iWrExec;
   logic iUpper;
   logic oGrantExec;
   logic oBusy;
   logic oLmar;
   logic oLmdr;
   logic oRm;
   logic oEnBus;
   logic oEnUN;
   logic oMemWe;
   logic oAckFetch;
   logic oAckExec;

   modport master (
      output iReqFetch, iReqExec, iWrExec, iUpper,
      input  oGrantExec, oBusy, oLmar, oLmdr, oRm, oEnBus, oEnUN, oMemWe,
             oAckFetch, oAckExec
   );

   modport slave (
      input  iReqFetch, iReqExec, iWrExec, iUpper,
      output oGrantExec, oBusy, oLmar, oLmdr, oRm, oEnBus, oEnUN, oMemWe,
             oAckFetch, oAckExec
   );

endinterface

// File: rtl/mdr_mem_sequencer_arb.sv
// Two-requester arbiter (bit 0 = fetch, bit 1 = exec); ties go to the side the
// pointer names and flip the pointer, single requests leave it alone.
module mdr_mem_sequencer_arb
   import mdr_mem_sequencer_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] grant
);

   logic ptr_q;
   logic ptr_d;

   always_comb begin
      grant = 2'b00;
      ptr_d = ptr_q;
      if (en) begin
         if (req == 2'b11) begin
            grant = (ptr_q == PTR_EXEC) ? 2'b10 : 2'b01;
            ptr_d = ~ptr_q;
         end else begin
            grant = req;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q <= PTR_FETCH;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/mdr_mem_sequencer.sv
// Sequences one RAM transaction at a time through the MAR/MDR, shared between
// the fetch and execute requesters; all control outputs are Moore-decoded.
module mdr_mem_sequencer
   import mdr_mem_sequencer_pkg::*;
#(
   parameter int RD_WAIT  = 1,
   parameter int WR_PULSE = 1,
   parameter int CW       = 3
) (
   input logic                iClk,
   input logic                iRst_n,
   mdr_mem_sequencer_if.slave bus
);

   localparam logic [CW-1:0] RD_LOAD = CW'(RD_WAIT);
   localparam logic [CW-1:0] WR_LOAD = CW'(WR_PULSE);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   seq_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          own_exec_q, own_exec_d;
   seq_op_e       op_q, op_d;
   logic          upper_q, upper_d;
   logic          arb_en;
   logic [1:0]    grant;

   assign arb_en = (state_q == ST_IDLE);

   mdr_mem_sequencer_arb u_arb (
      .clk   (iClk),
      .rst_n (iRst_n),
      .en    (arb_en),
      .req   ({bus.iReqExec, bus.iReqFetch}),
      .grant (grant)
   );

   // Op flags are captured only at the grant; fetch is always a lower-byte read.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      own_exec_d = own_exec_q;
      op_d       = op_q;
      upper_d    = upper_q;
      case (state_q)
         ST_IDLE: begin
            if (grant != 2'b00) begin
               state_d    = ST_ADDR;
               own_exec_d = grant[1];
               op_d       = (grant[1] && bus.iWrExec) ? OP_WR : OP_RD;
               upper_d    = grant[1] && bus.iUpper;
            end
         end
         ST_ADDR: begin
            if (op_q == OP_WR) begin
               state_d = ST_WLOAD;
            end else if (RD_WAIT > 0) begin
               state_d = ST_RWAIT;
               cnt_d   = RD_LOAD;
            end else begin
               state_d = ST_RLATCH;
            end
         end
         ST_RWAIT: begin
            if (cnt_q == CNT_ONE) state_d = ST_RLATCH;
            else                  cnt_d   = cnt_q - CNT_ONE;
         end
         ST_RLATCH:  state_d = ST_RDRIVE;
         ST_RDRIVE:  state_d = ST_IDLE;
         ST_WLOAD: begin
            state_d = ST_WSTROBE;
            cnt_d   = WR_LOAD;
         end
         ST_WSTROBE: begin
            if (cnt_q == CNT_ONE) state_d = ST_WDONE;
            else                  cnt_d   = cnt_q - CNT_ONE;
         end
         ST_WDONE:   state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         own_exec_q <= 1'b0;
         op_q       <= OP_RD;
         upper_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         own_exec_q <= own_exec_d;
         op_q       <= op_d;
         upper_q    <= upper_d;
      end
   end

   always_comb begin
      bus.oBusy      = (state_q != ST_IDLE);
      bus.oGrantExec = (state_q != ST_IDLE) && own_exec_q;
      bus.oLmar      = 1'b0;
      bus.oLmdr      = 1'b0;
      bus.oRm        = RM_READ;
      bus.oEnBus     = 1'b0;
      bus.oEnUN      = 1'b0;
      bus.oMemWe     = 1'b0;
      bus.oAckFetch  = 1'b0;
      bus.oAckExec   = 1'b0;
      case (state_q)
         ST_ADDR:    bus.oLmar = 1'b1;
         ST_RLATCH:  bus.oLmdr = 1'b1;
         ST_RDRIVE: begin
            bus.oEnBus    = ~upper_q;
            bus.oEnUN     = upper_q;
            bus.oAckFetch = ~own_exec_q;
            bus.oAckExec  = own_exec_q;
         end
         ST_WLOAD: begin
            bus.oLmdr = 1'b1;
            bus.oRm   = RM_WRITE;
         end
         ST_WSTROBE: begin
            bus.oRm    = RM_WRITE;
            bus.oMemWe = 1'b1;
         end
         ST_WDONE: begin
            bus.oRm       = RM_WRITE;
            bus.oAckFetch = ~own_exec_q;
            bus.oAckExec  = own_exec_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mdr_mem_sequencer.sv
// Bench for mdr_mem_sequencer: three instances with different wait/pulse
// settings, directed timelines plus a random request mix against a step model.
module tb_mdr_mem_sequencer;

   logic clk;
   logic rst_n;
   logic [2:0] req_f;
   logic [2:0] req_e;
   logic [2:0] wr_e;
   logic [2:0] up;
   wire  [2:0][9:0] obs;

   int total = 0;
   int bad   = 0;

   int rdw_p [3] = '{1, 0, 3};
   int wrp_p [3] = '{2, 1, 4};

   mdr_mem_sequencer_if if0 ();
   mdr_mem_sequencer_if if1 ();
   mdr_mem_sequencer_if if2 ();

   assign if0.iReqFetch = req_f[0];
   assign if0.iReqExec  = req_e[0];
   assign if0.iWrExec   = wr_e[0];
   assign if0.iUpper    = up[0];
   assign if1.iReqFetch = req_f[1];
   assign if1.iReqExec  = req_e[1];
   assign if1.iWrExec   = wr_e[1];
   assign if1.iUpper    = up[1];
   assign if2.iReqFetch = req_f[2];
   assign if2.iReqExec  = req_e[2];
   assign if2.iWrExec   = wr_e[2];
   assign if2.iUpper    = up[2];

   // Bit order: grant busy lmar lmdr rm enbus enun memwe ackf acke.
   assign obs[0] = {if0.oGrantExec, if0.oBusy, if0.oLmar, if0.oLmdr, if0.oRm,
                    if0.oEnBus, if0.oEnUN, if0.oMemWe, if0.oAckFetch, if0.oAckExec};
   assign obs[1] = {if1.oGrantExec, if1.oBusy, if1.oLmar, if1.oLmdr, if1.oRm,
                    if1.oEnBus, if1.oEnUN, if1.oMemWe, if1.oAckFetch, if1.oAckExec};
   assign obs[2] = {if2.oGrantExec, if2.oBusy, if2.oLmar, if2.oLmdr, if2.oRm,
                    if2.oEnBus, if2.oEnUN, if2.oMemWe, if2.oAckFetch, if2.oAckExec};

   mdr_mem_sequencer #(.RD_WAIT(1), .WR_PULSE(2), .CW(3)) u_dut0 (
      .iClk(clk), .iRst_n(rst_n), .bus(if0));
   mdr_mem_sequencer #(.RD_WAIT(0), .WR_PULSE(1), .CW(3)) u_dut1 (
      .iClk(clk), .iRst_n(rst_n), .bus(if1));
   mdr_mem_sequencer #(.RD_WAIT(3), .WR_PULSE(4), .CW(3)) u_dut2 (
      .iClk(clk), .iRst_n(rst_n), .bus(if2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Transaction model: each grant starts a fixed-length sequence of steps.
   bit m_act  [3];
   bit m_own  [3];
   bit m_wr   [3];
   bit m_up   [3];
   bit m_tie  [3];
   int m_step [3];

   function automatic bit pick_exec(input bit f, input bit e, input bit tie);
      return (f && e) ? tie : e;
   endfunction

   function automatic int txn_len(input int k);
      return m_wr[k] ? 3 + wrp_p[k] : 3 + rdw_p[k];
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (!rst_n) begin
            m_act[k]  <= 1'b0;
            m_step[k] <= 0;
            m_tie[k]  <= 1'b0;
         end else if (m_act[k]) begin
            if (m_step[k] + 1 == txn_len(k)) m_act[k] <= 1'b0;
            m_step[k] <= m_step[k] + 1;
         end else if (req_f[k] || req_e[k]) begin
            if (req_f[k] && req_e[k]) m_tie[k] <= !m_tie[k];
            m_own[k]  <= pick_exec(req_f[k], req_e[k], m_tie[k]);
            m_wr[k]   <= pick_exec(req_f[k], req_e[k], m_tie[k]) && wr_e[k];
            m_up[k]   <= pick_exec(req_f[k], req_e[k], m_tie[k]) && up[k];
            m_act[k]  <= 1'b1;
            m_step[k] <= 0;
         end
      end
   end

   function automatic logic [9:0] expect_vec(input int k);
      logic [9:0] v;
      int s;
      v = '0;
      s = m_step[k];
      if (m_act[k]) begin
         v[9] = m_own[k];
         v[8] = 1'b1;
         if (s == 0) begin
            v[7] = 1'b1;
         end else if (!m_wr[k]) begin
            if (s == rdw_p[k] + 1) v[6] = 1'b1;
            else if (s == rdw_p[k] + 2) begin
               if (m_up[k]) v[3] = 1'b1;
               else         v[4] = 1'b1;
               if (m_own[k]) v[0] = 1'b1;
               else          v[1] = 1'b1;
            end
         end else begin
            v[5] = 1'b1;
            if (s == 1) v[6] = 1'b1;
            else if (s <= wrp_p[k] + 1) v[2] = 1'b1;
            else if (m_own[k]) v[0] = 1'b1;
            else v[1] = 1'b1;
         end
      end
      return v;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      req_f = '0;
      req_e = '0;
      wr_e  = '0;
      up    = '0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         total++;
         if (obs[k] !== 10'h000) begin
            bad++;
            $display("[TB] FAIL reset_outputs dut%0d got=%h want=%h", k, obs[k], 10'h000);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_fetch_read();
      logic [9:0] tl [6] = '{10'h180, 10'h100, 10'h140, 10'h112, 10'h000, 10'h000};
      req_f[0] = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         total++;
         if (obs[0] !== tl[c-1]) begin
            bad++;
            $display("[TB] FAIL fetch_read c%0d got=%h want=%h", c, obs[0], tl[c-1]);
         end
         if (obs[0][1]) req_f[0] = 1'b0;
      end
      req_f[0] = 1'b0;
   endtask

   task automatic test_exec_write();
      logic [9:0] tl [7] = '{10'h380, 10'h360, 10'h324, 10'h324, 10'h321, 10'h000, 10'h000};
      wr_e[0]  = 1'b1;
      req_e[0] = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         total++;
         if (obs[0] !== tl[c-1]) begin
            bad++;
            $display("[TB] FAIL exec_write c%0d got=%h want=%h", c, obs[0], tl[c-1]);
         end
         if (obs[0][0]) req_e[0] = 1'b0;
      end
      req_e[0] = 1'b0;
      wr_e[0]  = 1'b0;
   endtask

   task automatic test_exec_read_upper();
      logic [9:0] tl [4] = '{10'h380, 10'h340, 10'h309, 10'h000};
      up[1]    = 1'b1;
      req_e[1] = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         total++;
         if (obs[1] !== tl[c-1]) begin
            bad++;
            $display("[TB] FAIL exec_read_upper c%0d got=%h want=%h", c, obs[1], tl[c-1]);
         end
         if (obs[1][0]) req_e[1] = 1'b0;
      end
      req_e[1] = 1'b0;
      up[1]    = 1'b0;
   endtask

   task automatic test_back_to_back();
      int order [$];
      int want [4] = '{0, 1, 1, 0};
      bit rearmed;
      bit done;
      logic [9:0] e;
      rearmed  = 1'b0;
      done     = 1'b0;
      req_f[0] = 1'b1;
      req_e[0] = 1'b1;
      for (int c = 0; c < 80 && !done; c++) begin
         @(negedge clk);
         e = expect_vec(0);
         total++;
         if (obs[0] !== e) begin
            bad++;
            $display("[TB] FAIL b2b_cycle c%0d got=%h want=%h", c, obs[0], e);
         end
         if (obs[0][7]) order.push_back(int'(obs[0][9]));
         if (obs[0][1]) req_f[0] = 1'b0;
         if (obs[0][0]) req_e[0] = 1'b0;
         if (!obs[0][8] && !req_f[0] && !req_e[0]) begin
            if (!rearmed && order.size() == 2) begin
               rearmed  = 1'b1;
               req_f[0] = 1'b1;
               req_e[0] = 1'b1;
            end else if (order.size() == 4) begin
               done = 1'b1;
            end
         end
      end
      total++;
      if (!done || order.size() != 4) begin
         bad++;
         $display("[TB] FAIL b2b_grants got=%0d want=%0d", order.size(), 4);
      end
      for (int i = 0; i < 4 && i < order.size(); i++) begin
         total++;
         if (order[i] != want[i]) begin
            bad++;
            $display("[TB] FAIL b2b_order[%0d] got=%0d want=%0d", i, order[i], want[i]);
         end
      end
      req_f[0] = 1'b0;
      req_e[0] = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit hit;
      hit      = 1'b0;
      wr_e[2]  = 1'b1;
      req_e[2] = 1'b1;
      for (int c = 0; c < 20 && !hit; c++) begin
         @(negedge clk);
         if (obs[2][2]) hit = 1'b1;
         total++;
         if (obs[2][0] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_mid_early_ack c%0d got=%b want=%b", c, obs[2][0], 1'b0);
         end
      end
      total++;
      if (!hit) begin
         bad++;
         $display("[TB] FAIL rst_mid_strobe got=%b want=%b", hit, 1'b1);
      end
      @(negedge clk);
      rst_n    = 1'b0;
      req_e[2] = 1'b0;
      @(negedge clk);
      total++;
      if (obs[2] !== 10'h000) begin
         bad++;
         $display("[TB] FAIL rst_mid_idle got=%h want=%h", obs[2], 10'h000);
      end
      rst_n    = 1'b1;
      req_e[2] = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         total++;
         if (obs[2] !== expect_vec(2)) begin
            bad++;
            $display("[TB] FAIL rst_mid_retry c%0d got=%h want=%h", c, obs[2], expect_vec(2));
         end
         if (c == 7) begin
            total++;
            if (obs[2][0] !== 1'b1) begin
               bad++;
               $display("[TB] FAIL rst_mid_ack_latency got=%b want=%b", obs[2][0], 1'b1);
            end
         end
         if (obs[2][0]) req_e[2] = 1'b0;
      end
      req_e[2] = 1'b0;
      wr_e[2]  = 1'b0;
   endtask

   task automatic test_random_mix();
      int lm [3] = '{0, 0, 0};
      int ak [3] = '{0, 0, 0};
      logic [9:0] e;
      logic [9:0] o;
      bit ok;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            e = expect_vec(k);
            o = obs[k];
            total++;
            if (o !== e) begin
               bad++;
               $display("[TB] FAIL rand_model dut%0d cyc%0d got=%h want=%h", k, cyc, o, e);
            end
            ok = !(o[2] && !o[5]) && !((o[4] || o[3]) && o[5]) && !(o[4] && o[3])
                 && !(o[7] && o[6]) && !(o[1] && o[0]);
            total++;
            if (!ok) begin
               bad++;
               $display("[TB] FAIL rand_invariant dut%0d cyc%0d got=%h want=%s", k, cyc, o, "legal");
            end
            if (o[7]) lm[k]++;
            if (o[1]) ak[k]++;
            if (o[0]) ak[k]++;
            if (o[1]) req_f[k] = 1'b0;
            else if (!req_f[k] && cyc < 1400 && $urandom_range(0, 3) == 0) req_f[k] = 1'b1;
            if (o[0]) req_e[k] = 1'b0;
            else if (!req_e[k]) begin
               wr_e[k] = 1'($urandom_range(0, 1));
               up[k]   = 1'($urandom_range(0, 1));
               if (cyc < 1400 && $urandom_range(0, 3) == 0) req_e[k] = 1'b1;
            end
         end
      end
      for (int k = 0; k < 3; k++) begin
         total++;
         if (ak[k] != lm[k] || lm[k] == 0) begin
            bad++;
            $display("[TB] FAIL rand_ack_count dut%0d got=%0d want=%0d", k, ak[k], lm[k]);
         end
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=%s want=%s", "timeout", "finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_fetch_read();
      test_exec_write();
      test_exec_read_upper();
      test_back_to_back();
      test_reset_mid();
      test_random_mix();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
